// File: rtl/if_fetch_unit.sv
// Instruction fetch front end. It issues word-aligned requests to instruction memory,
// collects in-order responses into a small buffer and hands instructions to decode.
module if_fetch_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 2
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] instr_pc,
    output logic [6:0]      op_code,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7
);

    localparam int              AW      = $clog2(DEPTH);
    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]     DEPTH_C = (CW+1)'(DEPTH);
    localparam logic [XLEN-1:0] NOP     = XLEN'(32'h0000_0013);

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction

    logic [XLEN-1:0] fetch_pc;
    logic [CW-1:0]   pending;
    logic [CW-1:0]   drop;
    logic [CW-1:0]   count;
    logic            boot;
    logic [AW-1:0]   buf_rd;
    logic [AW-1:0]   buf_wr;
    logic [AW-1:0]   pcq_rd;
    logic [AW-1:0]   pcq_wr;

    logic [XLEN-1:0] buf_data [DEPTH];
    logic [XLEN-1:0] buf_pc   [DEPTH];
    logic [XLEN-1:0] pcq      [DEPTH];

    logic [CW:0] occupancy;
    logic        req_fire;
    logic        rsp_take;
    logic        push;
    logic        pop;

    // In-flight requests and buffered entries share one budget, so the buffer can never overflow.
    assign occupancy      = {1'b0, pending} + {1'b0, count};
    assign imem_req_valid = !rst && boot && !redirect_valid && (occupancy < DEPTH_C);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response arriving in the redirect cycle belongs to the old path and is discarded.
    assign rsp_take = imem_rsp_valid && (pending != '0);
    assign push     = rsp_take && (drop == '0) && !redirect_valid;

    assign instr_valid = !rst && (count != '0);
    assign pop         = instr_valid && instr_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            pending  <= '0;
            drop     <= '0;
            count    <= '0;
            boot     <= 1'b0;
            buf_rd   <= '0;
            buf_wr   <= '0;
            pcq_rd   <= '0;
            pcq_wr   <= '0;
        end else begin
            boot    <= 1'b1;
            pending <= pending + CW'(req_fire) - CW'(rsp_take);
            if (req_fire) pcq_wr <= pcq_wr + AW'(1);
            if (rsp_take) pcq_rd <= pcq_rd + AW'(1);
            if (redirect_valid) begin
                fetch_pc <= align_pc(redirect_pc);
                drop     <= pending - CW'(rsp_take);
                count    <= '0;
                buf_rd   <= '0;
                buf_wr   <= '0;
            end else begin
                if (req_fire) fetch_pc <= fetch_pc + XLEN'(4);
                if (rsp_take && (drop != '0)) drop <= drop - CW'(1);
                count <= count + CW'(push) - CW'(pop);
                if (push) buf_wr <= buf_wr + AW'(1);
                if (pop)  buf_rd <= buf_rd + AW'(1);
            end
        end
    end

    // Payload storage carries no reset; occupancy is tracked by the counters above.
    always_ff @(posedge clk) begin
        if (req_fire) pcq[pcq_wr] <= fetch_pc;
        if (push) begin
            buf_data[buf_wr] <= imem_rsp_data;
            buf_pc[buf_wr]   <= pcq[pcq_rd];
        end
    end

    assign instr    = instr_valid ? buf_data[buf_rd] : NOP;
    assign instr_pc = instr_valid ? buf_pc[buf_rd] : '0;
    assign op_code  = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];

endmodule

// File: tb/tb_if_fetch_unit.sv
// Randomized bench for if_fetch_unit: a transaction-level model of the PC stream,
// in-flight requests and decode buffer predicts every output on every cycle.
module tb_if_fetch_unit;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'hFFFF_FFF8;
    localparam logic [31:0] KEY      = 32'hA5A5_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic            clk;
    logic            rst;
    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [XLEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic            instr_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] instr_pc;
    logic [6:0]      op_code;
    logic [2:0]      funct3;
    logic [6:0]      funct7;

    if_fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .instr_pc(instr_pc),
        .op_code(op_code), .funct3(funct3), .funct7(funct7)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        int          due;
        bit          stale;
    } req_t;

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    req_t        mq[$];
    ent_t        eb[$];
    logic [31:0] acc[$];
    logic [31:0] pops[$];
    logic [31:0] mpc;
    int          cyc;
    int          since_rst;

    int          p_rdy, p_irdy, p_redir, lat_min, lat_max;
    bit          force_redir;
    logic [31:0] force_pc;
    logic        last_rv, last_iv;
    logic [31:0] last_addr;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] acc_at(input int i);
        return (i < acc.size()) ? acc[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] pop_at(input int i);
        return (i < pops.size()) ? pops[i] : 32'hDEAD_BEEF;
    endfunction

    // One clock cycle: drive at posedge+1, check at negedge, advance the model after posedge.
    task automatic cycle();
        req_t        r;
        ent_t        e;
        bit          fire, pop, rsp, redir, exp_rv, exp_iv;
        logic [31:0] rpc;
        int          lat;
        imem_req_ready = ($urandom_range(99) < p_rdy);
        instr_ready    = ($urandom_range(99) < p_irdy);
        if (force_redir) begin
            redirect_valid = 1'b1;
            redirect_pc    = force_pc;
            force_redir    = 1'b0;
        end else begin
            redirect_valid = ($urandom_range(99) < p_redir);
            redirect_pc    = $urandom;
        end
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mq[0].addr ^ KEY;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = $urandom;
        end
        @(negedge clk);
        exp_rv = (since_rst >= 1) && !redirect_valid && (mq.size() + eb.size() < DEPTH);
        chk("req_valid", imem_req_valid, exp_rv);
        if (exp_rv && imem_req_valid) chk("req_addr", imem_req_addr, mpc);
        exp_iv = (eb.size() > 0);
        chk("instr_valid", instr_valid, exp_iv);
        if (exp_iv) begin
            e = eb[0];
            chk("instr", instr, e.data);
            chk("instr_pc", instr_pc, e.pc);
            chk("op_code", op_code, e.data[6:0]);
            chk("funct3", funct3, e.data[14:12]);
            chk("funct7", funct7, e.data[31:25]);
        end else begin
            chk("instr_idle", instr, NOP);
            chk("instr_pc_idle", instr_pc, 0);
        end
        fire      = imem_req_valid && imem_req_ready;
        pop       = instr_valid && instr_ready;
        rsp       = imem_rsp_valid;
        redir     = redirect_valid;
        rpc       = redirect_pc;
        last_rv   = imem_req_valid;
        last_iv   = instr_valid;
        last_addr = imem_req_addr;
        if (fire) acc.push_back(imem_req_addr);
        if (pop)  pops.push_back(instr_pc);
        lat = $urandom_range(lat_max, lat_min);
        @(posedge clk);
        #1;
        if (pop && eb.size() > 0) void'(eb.pop_front());
        if (rsp) begin
            r = mq.pop_front();
            if (!r.stale && !redir) begin
                e.data = r.addr ^ KEY;
                e.pc   = r.addr;
                eb.push_back(e);
            end
        end
        if (redir) begin
            eb.delete();
            foreach (mq[i]) mq[i].stale = 1'b1;
            mpc = rpc & ~32'h3;
        end else if (fire) begin
            r.addr  = mpc;
            r.due   = cyc + lat;
            r.stale = 1'b0;
            mq.push_back(r);
            mpc = mpc + 32'd4;
        end
        cyc++;
        since_rst++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // Memory is reset together with the unit, so its response queue is cleared too.
    task automatic do_reset(input int n);
        rst            = 1'b1;
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        force_redir    = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("rst_req_valid", imem_req_valid, 0);
            chk("rst_instr_valid", instr_valid, 0);
            chk("rst_instr", instr, NOP);
            chk("rst_instr_pc", instr_pc, 0);
            @(posedge clk);
            #1;
            cyc++;
        end
        rst = 1'b0;
        mq.delete();
        eb.delete();
        mpc       = RESET_PC;
        since_rst = 0;
    endtask

    initial begin
        bit found;
        rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
        cyc = 0; since_rst = 0; mpc = RESET_PC; force_redir = 1'b0; force_pc = '0;
        last_rv = 1'b0; last_iv = 1'b0; last_addr = '0;
        p_rdy = 100; p_irdy = 100; p_redir = 0; lat_min = 1; lat_max = 1;

        do_reset(3);

        // Straight-line fetch from a reset PC near the top of memory; addresses wrap.
        acc.delete(); pops.delete();
        run(12);
        chk("t1_addr0", acc_at(0), 32'hFFFF_FFF8);
        chk("t1_addr1", acc_at(1), 32'hFFFF_FFFC);
        chk("t1_addr2", acc_at(2), 32'h0000_0000);
        chk("t1_addr3", acc_at(3), 32'h0000_0004);
        chk("t1_pc0", pop_at(0), 32'hFFFF_FFF8);
        chk("t1_pc1", pop_at(1), 32'hFFFF_FFFC);
        chk("t1_pc2", pop_at(2), 32'h0000_0000);

        // Decode stalled: buffer fills and request issue stops.
        p_irdy = 0;
        run(10);
        chk("t2_req_valid_full", last_rv, 0);
        chk("t2_instr_valid_full", last_iv, 1);
        p_irdy = 100;
        run(4);

        // Memory not ready: address held at 8 until accepted, then one increment.
        force_redir = 1'b1; force_pc = 32'h0;
        run(1);
        acc.delete();
        for (int i = 0; i < 20 && acc.size() < 2; i++) cycle();
        p_rdy = 0;
        run(3);
        chk("t3_valid_held", last_rv, 1);
        chk("t3_addr_held", last_addr, 32'h8);
        p_rdy = 100;
        acc.delete();
        run(3);
        chk("t3_accept0", acc_at(0), 32'h8);
        chk("t3_accept1", acc_at(1), 32'hC);

        // Redirect with two requests in flight and a misaligned target.
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && mq.size() < 2; i++) cycle();
        force_redir = 1'b1; force_pc = 32'h0000_0103;
        run(1);
        lat_min = 1; lat_max = 1;
        acc.delete(); pops.delete();
        run(8);
        chk("t4_first_addr", acc_at(0), 32'h100);
        chk("t4_first_pc", pop_at(0), 32'h100);

        // Redirect in the same cycle as a response and a pop.
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (mq.size() > 0 && mq[0].due <= cyc && eb.size() > 0) begin
                found = 1'b1;
                force_redir = 1'b1; force_pc = 32'h200;
                pops.delete();
                cycle();
                chk("t5_pop_honored", pops.size(), 1);
                pops.delete();
                run(1);
                chk("t5_instr_valid_next", last_iv, 0);
                run(6);
                chk("t5_first_pc", pop_at(0), 32'h200);
            end else begin
                cycle();
            end
        end
        if (!found) chk("t5_setup_reached", 0, 1);

        // Random traffic, redirects and memory latency.
        p_rdy = 70; p_irdy = 60; p_redir = 5; lat_min = 1; lat_max = 4;
        run(3000);

        // Reset in the middle of traffic.
        do_reset(1);
        run(2);
        chk("t6_rst_req_valid", last_rv, 1);
        chk("t6_rst_addr", last_addr, RESET_PC);
        run(500);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
